// File: rtl/d_e_ctrl_pipe_pkg.sv
// Shared encodings and control-word types for the D/E control pipeline.
// ALU op codes, MIPS opcode/funct constants and the Tnew/Tuse width live here.
package d_e_ctrl_pipe_pkg;

  localparam int TNEW_W = 2;
  localparam int TUSE_W = 2;

  localparam logic [4:0] ALU_ADDU = 5'd0;
  localparam logic [4:0] ALU_SUBU = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_LUI  = 5'd4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // Operand never read: larger than any Tnew, so it can never stall.
  localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [4:0]        alu_op;
    logic              alu_src;
    logic [31:0]       imm;
    logic              reg_write;
    logic              mem_write;
    logic              mem_to_reg;
    logic              link;
    logic [4:0]        a3;
    logic [TNEW_W-1:0] tnew;
  } ctrl_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic              mem_to_reg;
    logic              link;
    logic [4:0]        a3;
    logic [TNEW_W-1:0] tnew;
  } ctrl_m_t;

  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/d_e_ctrl_pipe_decode.sv
// Combinational decoder: D-stage instruction to control word plus operand Tuse.
// Unrecognised encodings yield the all-zero (nop) word.
module instr_decode
  import d_e_ctrl_pipe_pkg::*;
(
  input  logic [31:0]       instr,
  output ctrl_t             ctrl,
  output logic [TUSE_W-1:0] tuse_rs,
  output logic [TUSE_W-1:0] tuse_rt
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] imm_zext;
  logic [31:0] imm_sext;
  logic        unused_bits;

  assign opcode      = instr[31:26];
  assign funct       = instr[5:0];
  assign rt          = instr[20:16];
  assign rd          = instr[15:11];
  assign imm_zext    = {16'h0000, instr[15:0]};
  assign imm_sext    = {{16{instr[15]}}, instr[15:0]};
  assign unused_bits = ^{instr[25:21], instr[10:6]};

  always_comb begin
    ctrl    = '0;
    tuse_rs = TUSE_NONE;
    tuse_rt = TUSE_NONE;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin
            ctrl.alu_op = ALU_ADDU;
            ctrl.a3     = rd;
            ctrl.tnew   = 2'd1;
            tuse_rs     = 2'd1;
            tuse_rt     = 2'd1;
          end
          FN_SUBU: begin
            ctrl.alu_op = ALU_SUBU;
            ctrl.a3     = rd;
            ctrl.tnew   = 2'd1;
            tuse_rs     = 2'd1;
            tuse_rt     = 2'd1;
          end
          FN_JR: tuse_rs = 2'd0;
          default: ;
        endcase
      end
      OP_ORI: begin
        ctrl.alu_op  = ALU_OR;
        ctrl.alu_src = 1'b1;
        ctrl.imm     = imm_zext;
        ctrl.a3      = rt;
        ctrl.tnew    = 2'd1;
        tuse_rs      = 2'd1;
      end
      OP_LUI: begin
        ctrl.alu_op  = ALU_LUI;
        ctrl.alu_src = 1'b1;
        ctrl.imm     = imm_zext;
        ctrl.a3      = rt;
        ctrl.tnew    = 2'd1;
      end
      OP_LW: begin
        ctrl.alu_op     = ALU_ADDU;
        ctrl.alu_src    = 1'b1;
        ctrl.imm        = imm_sext;
        ctrl.mem_to_reg = 1'b1;
        ctrl.a3         = rt;
        ctrl.tnew       = 2'd2;
        tuse_rs         = 2'd1;
      end
      OP_SW: begin
        ctrl.alu_op    = ALU_ADDU;
        ctrl.alu_src   = 1'b1;
        ctrl.imm       = imm_sext;
        ctrl.mem_write = 1'b1;
        tuse_rs        = 2'd1;
        tuse_rt        = 2'd2;
      end
      OP_BEQ: begin
        tuse_rs = 2'd0;
        tuse_rt = 2'd0;
      end
      OP_JAL: begin
        ctrl.link = 1'b1;
        ctrl.a3   = 5'd31;
      end
      default: ;
    endcase
    // Writes to $0 are discarded so they never look like a hazard producer.
    ctrl.reg_write = (ctrl.a3 != 5'd0);
  end

endmodule

// File: rtl/d_e_ctrl_pipe.sv
// D/E and E/M control registers with Tnew tracking and RAW stall detection.
// A stalled D instruction is replaced by an all-zero bubble in E.
module d_e_ctrl_pipe
  import d_e_ctrl_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_D,
  output logic        Stall_D,
  output logic [4:0]  ALUOp_E,
  output logic        ALUSrc_E,
  output logic [31:0] Imm_E,
  output logic        RegWrite_E,
  output logic        MemWrite_E,
  output logic        MemToReg_E,
  output logic        Link_E,
  output logic [4:0]  A3_E,
  output logic [1:0]  Tnew_E,
  output logic        RegWrite_M,
  output logic        MemWrite_M,
  output logic        MemToReg_M,
  output logic        Link_M,
  output logic [4:0]  A3_M,
  output logic [1:0]  Tnew_M
);

  ctrl_t             dec_ctrl;
  logic [TUSE_W-1:0] tuse_rs;
  logic [TUSE_W-1:0] tuse_rt;
  logic [4:0]        rs;
  logic [4:0]        rt;
  ctrl_t             ctrl_e_p1;
  ctrl_m_t           ctrl_m_p2;

  instr_decode u_decode (
    .instr   (Instr_D),
    .ctrl    (dec_ctrl),
    .tuse_rs (tuse_rs),
    .tuse_rt (tuse_rt)
  );

  assign rs = Instr_D[25:21];
  assign rt = Instr_D[20:16];

  function automatic logic raw_hazard(input logic [4:0]        r,
                                      input logic [TUSE_W-1:0] tuse,
                                      input logic              rw,
                                      input logic [4:0]        a3,
                                      input logic [TNEW_W-1:0] tnew);
    return (r != 5'd0) && rw && (a3 == r) && (tnew > tuse);
  endfunction

  always_comb begin
    Stall_D = raw_hazard(rs, tuse_rs, ctrl_e_p1.reg_write, ctrl_e_p1.a3, ctrl_e_p1.tnew)
            | raw_hazard(rs, tuse_rs, ctrl_m_p2.reg_write, ctrl_m_p2.a3, ctrl_m_p2.tnew)
            | raw_hazard(rt, tuse_rt, ctrl_e_p1.reg_write, ctrl_e_p1.a3, ctrl_e_p1.tnew)
            | raw_hazard(rt, tuse_rt, ctrl_m_p2.reg_write, ctrl_m_p2.a3, ctrl_m_p2.tnew);
  end

  // D -> E (p1) and E -> M (p2) stage boundaries
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_e_p1 <= '0;
      ctrl_m_p2 <= '0;
    end else begin
      ctrl_e_p1            <= Stall_D ? '0 : dec_ctrl;
      ctrl_m_p2.reg_write  <= ctrl_e_p1.reg_write;
      ctrl_m_p2.mem_write  <= ctrl_e_p1.mem_write;
      ctrl_m_p2.mem_to_reg <= ctrl_e_p1.mem_to_reg;
      ctrl_m_p2.link       <= ctrl_e_p1.link;
      ctrl_m_p2.a3         <= ctrl_e_p1.a3;
      ctrl_m_p2.tnew       <= tnew_dec(ctrl_e_p1.tnew);
    end
  end

  assign ALUOp_E    = ctrl_e_p1.alu_op;
  assign ALUSrc_E   = ctrl_e_p1.alu_src;
  assign Imm_E      = ctrl_e_p1.imm;
  assign RegWrite_E = ctrl_e_p1.reg_write;
  assign MemWrite_E = ctrl_e_p1.mem_write;
  assign MemToReg_E = ctrl_e_p1.mem_to_reg;
  assign Link_E     = ctrl_e_p1.link;
  assign A3_E       = ctrl_e_p1.a3;
  assign Tnew_E     = ctrl_e_p1.tnew;
  assign RegWrite_M = ctrl_m_p2.reg_write;
  assign MemWrite_M = ctrl_m_p2.mem_write;
  assign MemToReg_M = ctrl_m_p2.mem_to_reg;
  assign Link_M     = ctrl_m_p2.link;
  assign A3_M       = ctrl_m_p2.a3;
  assign Tnew_M     = ctrl_m_p2.tnew;

endmodule
